jk_reg_bank: RTL and testbench

JK_REG_BANK -- requirements
Module: jk_reg_bank

---
 rtl/jk_reg_bank.sv | 103 ++++++++++
 tb/tb_jk_reg_bank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: a bank of WIDTH JK flip-flops that can also count up, count
// down or parallel-load as a whole word. A combinational terminal-count flag
// marks the state from which the next counting edge wraps. A registered
// one-cycle pulse reports that such a wrap has happened.
module jk_reg_bank #(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_JK    = 2'b00,
        MODE_UP    = 2'b01,
        MODE_DOWN  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    mode_e            mode_sel;

    // Per-bit JK rule. J sets, K clears, J and K together toggle, and
    // neither holds the bit.
    function automatic logic [WIDTH-1:0] jk_next(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] jv,
        input logic [WIDTH-1:0] kv
    );
        jk_next = (jv & ~cur) | (~kv & cur);
    endfunction

    // Modular increment. All-ones rolls over to zero.
    function automatic logic [WIDTH-1:0] inc_wrap(input logic [WIDTH-1:0] cur);
        inc_wrap = cur + ONE;
    endfunction

    // Modular decrement. Zero rolls under to all-ones.
    function automatic logic [WIDTH-1:0] dec_wrap(input logic [WIDTH-1:0] cur);
        dec_wrap = cur - ONE;
    endfunction

    assign mode_sel = mode_e'(mode);

    // Terminal count looks only at the mode and the current state. It does not
    // look at en, so it can warn of a wrap that the next enabled edge would cause.
    always_comb begin
        tc = 1'b0;
        unique case (mode_sel)
            MODE_UP:   tc = (q_q == ALL_ONES);
            MODE_DOWN: tc = (q_q == '0);
            default:   tc = 1'b0;
        endcase
    end

    // Next-state selection. Inputs that belong to other modes are never
    // looked at. A wrap is flagged only for a counting edge taken from the
    // terminal state.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (en) begin
            wrap_d = tc;
            unique case (mode_sel)
                MODE_JK:   q_d = jk_next(q_q, j, k);
                MODE_UP:   q_d = inc_wrap(q_q);
                MODE_DOWN: q_d = dec_wrap(q_q);
                MODE_LOAD: q_d = d;
                default:   q_d = q_q;
            endcase
        end
    end

    // State and wrap registers. The asynchronous reset overrides everything,
    // including an update or wrap that is already in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= RST_VAL;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed testbench for jk_reg_bank: a default 4-bit instance, plus an 8-bit
// instance with a non-zero reset value that shares the control inputs.
module tb_jk_reg_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j, k, d;
    logic [3:0] q, qbar;
    logic       tc, wrap;

    logic [7:0] j8, k8, d8;
    logic [7:0] q8, qbar8;
    logic       tc8, wrap8;

    int checks;
    int failures;

    assign j8 = {4'b0000, j};
    assign k8 = {4'b0000, k};
    assign d8 = {4'b0000, d};

    jk_reg_bank dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .j    (j),
        .k    (k),
        .d    (d),
        .q    (q),
        .qbar (qbar),
        .tc   (tc),
        .wrap (wrap)
    );

    jk_reg_bank #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .j    (j8),
        .k    (k8),
        .d    (d8),
        .q    (q8),
        .qbar (qbar8),
        .tc   (tc8),
        .wrap (wrap8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst  = 1'b1;
        en   = 1'b1;
        mode = 2'b01;
        j    = 4'b0000;
        k    = 4'b0000;
        d    = 4'b0000;

        // Reset asserted before any clock edge takes effect asynchronously.
        #2 rst = 1'b0;
        #1;
        check("rst_async_q", q, 4'b0000);
        check("rst_async_qbar", qbar, 4'b1111);
        check("rst_async_wrap", wrap, 1'b0);
        check("rst_async_q8", q8, 8'hA5);

        // The clock keeps running with en=1 and mode=up, but reset holds.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_q", q, 4'b0000);
            check("rst_hold_qbar", qbar, 4'b1111);
            check("rst_hold_wrap", wrap, 1'b0);
        end

        // Release between edges. The first edge after release counts.
        rst = 1'b1;
        tick();
        check("rel_first_q", q, 4'b0001);

        // JK truth table.
        mode = 2'b11; d = 4'b0101; j = 4'b1111; k = 4'b1111;
        tick();
        check("jk_load", q, 4'b0101);
        mode = 2'b00; j = 4'b0011; k = 4'b0110; d = 4'b1111;
        tick();
        check("jk_mix", q, 4'b0011);
        check("jk_mix_wrap", wrap, 1'b0);
        j = 4'b1111; k = 4'b1111;
        #1 check("jk_tc", tc, 1'b0);
        tick();
        check("jk_toggle", q, 4'b1100);
        check("jk_toggle_qbar", qbar, 4'b0011);
        j = 4'b0000; k = 4'b0000;
        tick();
        check("jk_hold", q, 4'b1100);
        check("jk_hold_wrap", wrap, 1'b0);

        // Count up through the all-ones wrap.
        mode = 2'b11; d = 4'b1110;
        tick();
        check("up_load", q, 4'b1110);
        mode = 2'b01;
        #1 check("up_tc_pre", tc, 1'b0);
        tick();
        check("up_q1", q, 4'b1111);
        check("up_tc1", tc, 1'b1);
        check("up_wrap1", wrap, 1'b0);
        tick();
        check("up_q2", q, 4'b0000);
        check("up_wrap2", wrap, 1'b1);
        check("up_tc2", tc, 1'b0);
        tick();
        check("up_q3", q, 4'b0001);
        check("up_wrap3", wrap, 1'b0);

        // Count down through the zero wrap.
        mode = 2'b11; d = 4'b0001;
        tick();
        check("dn_load", q, 4'b0001);
        mode = 2'b10;
        tick();
        check("dn_q1", q, 4'b0000);
        check("dn_tc1", tc, 1'b1);
        check("dn_wrap1", wrap, 1'b0);
        tick();
        check("dn_q2", q, 4'b1111);
        check("dn_wrap2", wrap, 1'b1);

        // Loading the terminal values never pulses wrap, and tc follows the mode.
        mode = 2'b11; d = 4'b0000;
        tick();
        check("ld0_q", q, 4'b0000);
        check("ld0_wrap", wrap, 1'b0);
        check("ld0_tc", tc, 1'b0);
        mode = 2'b10;
        #1 check("tc_dn_zero", tc, 1'b1);
        mode = 2'b01;
        #1 check("tc_up_zero", tc, 1'b0);
        mode = 2'b11; d = 4'b1111;
        tick();
        check("ld1_q", q, 4'b1111);
        tick();
        check("ld1_wrap", wrap, 1'b0);

        // Enable gating while sitting at the terminal count.
        mode = 2'b01; en = 1'b0; d = 4'b0101; j = 4'b1111; k = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en0_q", q, 4'b1111);
            check("en0_tc", tc, 1'b1);
            check("en0_wrap", wrap, 1'b0);
        end
        en = 1'b1;
        tick();
        check("en1_q", q, 4'b0000);
        check("en1_wrap", wrap, 1'b1);
        en = 1'b0;
        tick();
        check("en0_after_wrap", wrap, 1'b0);
        check("en0_after_q", q, 4'b0000);

        // Mid-operation reset on both widths.
        en = 1'b1; mode = 2'b11; d = 4'b0000;
        tick();
        check("mr_load4", q, 4'b0000);
        check("mr_load8", q8, 8'h00);
        mode = 2'b01;
        for (int i = 0; i < 6; i++) tick();
        check("mr_pre4", q, 4'b0110);
        check("mr_pre8", q8, 8'h06);
        #2 rst = 1'b0;
        #1;
        check("mr_q4", q, 4'b0000);
        check("mr_qbar4", qbar, 4'b1111);
        check("mr_q8", q8, 8'hA5);
        check("mr_qbar8", qbar8, 8'h5A);
        check("mr_wrap8", wrap8, 1'b0);
        tick();
        check("mr_hold4", q, 4'b0000);
        check("mr_hold8", q8, 8'hA5);
        rst = 1'b1;
        tick();
        check("mr_rel4", q, 4'b0001);
        check("mr_rel8", q8, 8'hA6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
